bk_add_sequencer: RTL and testbench



---
 rtl/bk_add_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bk_add_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_add_sequencer.sv
// -----------------------------------------------------------------------------
// bk_add_sequencer
//
// Drives a shared 4-bit Brent-Kung adder core one nibble per clock to build a
// WIDTH-bit addition. Both operands are captured on a start request. Nibbles
// are presented LSB first, and each nibble's carry-out is chained into the
// next nibble's carry-in. The sum nibbles are collected into a held result.
//
// Optional feature macro: BK_SEQ_SUB_EN
//   When defined, an extra 'sub' input is sampled with start. If sub=1,
//   B is latched inverted and the chain starts with carry=1, so the result is
//   a_in - b_in mod 2^WIDTH. carry_out=1 then means no borrow (a_in >= b_in).
//   When undefined there is no 'sub' port and the chain always starts at 0.
//
// Parameters:
//   NIBBLES   number of 4-bit slices per operand (>= 1)
//   WIDTH     4*NIBBLES, derived; do not override
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   start      one-cycle request, only honoured in IDLE
//   sub        (BK_SEQ_SUB_EN only) subtract request, sampled with start
//   a_in/b_in  operands, sampled with start
//   add_a/add_b/add_cin  nibble operands and carry-in to the adder core
//   add_sum/add_cout     combinational result from the adder core
//   busy       high in RUN and DONE
//   done       one-cycle pulse when the result is valid
//   sum        result, held until the next accepted start
//   carry_out  final carry, held with sum
//
// States:
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; adder core inputs held at 0
//   RUN    | one nibble per cycle through the core, idx = current nibble
//   DONE   | result valid, done pulses for this single cycle
// -----------------------------------------------------------------------------
module bk_add_sequencer #(
  parameter int NIBBLES = 4,
  parameter int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BK_SEQ_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+1:0] nib_lsb;
  logic             is_last;
  logic             load;
  logic             step;
  logic             sub_op;

`ifdef BK_SEQ_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  // Bit offset of the current nibble inside the operand/result words.
  assign nib_lsb = {idx, 2'b00};
  assign is_last = (idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. Adder core inputs are forced to zero outside RUN
  // so the shared core sees quiet inputs while this sequencer is idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    load      = 1'b0;
    step      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        busy    = 1'b1;
        step    = 1'b1;
        add_a   = a_reg[nib_lsb +: 4];
        add_b   = b_reg[nib_lsb +: 4];
        add_cin = carry;
        if (is_last) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, carry chain, result collection.
  // Subtraction is a + ~b + 1, so B is stored inverted and the chain is seeded
  // with carry=1; the per-nibble loop is then identical for add and subtract.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (load) begin
      a_reg     <= a_in;
      b_reg     <= sub_op ? ~b_in : b_in;
      carry     <= sub_op;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (step) begin
      sum[nib_lsb +: 4] <= add_sum;
      carry             <= add_cout;
      if (is_last) begin
        // Wrap so idx never points past the operand for non power-of-two sizes.
        idx       <= '0;
        carry_out <= add_cout;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bk_add_sequencer.sv
module tb_bk_add_sequencer;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          sub_s;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_sum;
  logic          add_cout;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          carry_out;

  // Single-nibble instance for the NIBBLES=1 boundary
  logic          start_1;
  logic [3:0]    a_in_1;
  logic [3:0]    b_in_1;
  logic [3:0]    add_a_1;
  logic [3:0]    add_b_1;
  logic          add_cin_1;
  logic [3:0]    add_sum_1;
  logic          add_cout_1;
  logic          busy_1;
  logic          done_1;
  logic [3:0]    sum_1;
  logic          carry_out_1;

  // Behavioural stand-in for the combinational 4-bit adder core
  assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign {add_cout_1, add_sum_1} = {1'b0, add_a_1} + {1'b0, add_b_1} + {4'b0, add_cin_1};

  bk_add_sequencer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef BK_SEQ_SUB_EN
    .sub       (sub_s),
`endif
    .a_in      (a_in),
    .b_in      (b_in),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  bk_add_sequencer #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_1),
`ifdef BK_SEQ_SUB_EN
    .sub       (1'b0),
`endif
    .a_in      (a_in_1),
    .b_in      (b_in_1),
    .add_a     (add_a_1),
    .add_b     (add_b_1),
    .add_cin   (add_cin_1),
    .add_sum   (add_sum_1),
    .add_cout  (add_cout_1),
    .busy      (busy_1),
    .done      (done_1),
    .sum       (sum_1),
    .carry_out (carry_out_1)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic [N-1:0] exp_cin;   // bit k = carry-in presented on RUN cycle k
  } vec_t;

  vec_t tbl[$];

  // Reference: carry into nibble k is the overflow of the lower 4k bits.
  function automatic logic [N-1:0] ref_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [N-1:0] r;
    longint unsigned m, eb, tot;
    eb = s ? longint'(~b) & 64'hFFFF : longint'(b);
    for (int k = 0; k < N; k++) begin
      m    = (64'd1 << (4 * k)) - 1;
      tot  = (longint'(a) & m) + (eb & m) + longint'(s);
      r[k] = tot[4*k];
    end
    return r;
  endfunction

  // One complete operation from IDLE; checks every cycle through the return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic [N-1:0] ecin,
                        input string tag);
    logic [W-1:0] eb;
    logic [N-1:0] cin_seen;
    eb       = s ? ~b : b;
    cin_seen = '0;
    a_in  = a;
    b_in  = b;
    sub_s = s;
    start = 1'b1;
    step();
    start = 1'b0;
    a_in  = ~a;   // operands must have been captured already
    b_in  = ~b;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_run%0d_busy", tag, k), {31'b0, busy}, 32'd1);
      chk($sformatf("%s_run%0d_done", tag, k), {31'b0, done}, 32'd0);
      chk($sformatf("%s_run%0d_add_a", tag, k), {28'b0, add_a}, {28'b0, a[4*k +: 4]});
      chk($sformatf("%s_run%0d_add_b", tag, k), {28'b0, add_b}, {28'b0, eb[4*k +: 4]});
      cin_seen[k] = add_cin;
      step();
    end
    chk($sformatf("%s_done_pulse", tag), {31'b0, done}, 32'd1);
    chk($sformatf("%s_done_busy", tag), {31'b0, busy}, 32'd1);
    chk($sformatf("%s_done_add_a", tag), {28'b0, add_a}, 32'd0);
    step();
    chk($sformatf("%s_done_off", tag), {31'b0, done}, 32'd0);
    chk($sformatf("%s_idle_busy", tag), {31'b0, busy}, 32'd0);
    chk($sformatf("%s_sum", tag), {16'b0, sum}, {16'b0, es});
    chk($sformatf("%s_carry_out", tag), {31'b0, carry_out}, {31'b0, ec});
    chk($sformatf("%s_cin_trace", tag), {28'b0, cin_seen}, {28'b0, ecin});
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;
    logic         rs;
    logic [W:0]   full;

    rst     = 1'b1;
    start   = 1'b0;
    sub_s   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    start_1 = 1'b0;
    a_in_1  = '0;
    b_in_1  = '0;

    tbl.push_back('{16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, 4'b0000});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110});
    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000});
    tbl.push_back('{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 4'b0000});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 4'b1110});
    tbl.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b0000});
    tbl.push_back('{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 4'b1010});
`ifdef BK_SEQ_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 4'b0001});
    tbl.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 4'b1111});
`endif

    step();
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_done",      {31'b0, done},      32'd0);
    chk("rst_sum",       {16'b0, sum},       32'd0);
    chk("rst_carry_out", {31'b0, carry_out}, 32'd0);
    chk("rst_add_a",     {28'b0, add_a},     32'd0);
    chk("rst_add_b",     {28'b0, add_b},     32'd0);
    chk("rst_add_cin",   {31'b0, add_cin},   32'd0);
    chk("rst_busy_n1",   {31'b0, busy_1},    32'd0);

    // Directed vector table
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp_sum, tbl[i].exp_cout,
             tbl[i].exp_cin, $sformatf("tbl%0d", i));
    end

    // Second start during RUN must be ignored
    a_in  = 16'h1234;
    b_in  = 16'h4321;
    sub_s = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    a_in  = 16'hFFFF;
    b_in  = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      step();
    end
    chk("ignore_done_count", ndone, 32'd1);
    chk("ignore_sum",        {16'b0, sum},       32'h5555);
    chk("ignore_carry_out",  {31'b0, carry_out}, 32'd0);
    chk("ignore_idle_busy",  {31'b0, busy},      32'd0);

    // Reset on the second RUN cycle
    a_in  = 16'hABCD;
    b_in  = 16'h1111;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy",      {31'b0, busy},      32'd0);
    chk("midrst_done",      {31'b0, done},      32'd0);
    chk("midrst_sum",       {16'b0, sum},       32'd0);
    chk("midrst_carry_out", {31'b0, carry_out}, 32'd0);
    chk("midrst_add_a",     {28'b0, add_a},     32'd0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      step();
    end
    chk("midrst_no_done", ndone, 32'd0);
    run_op(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 4'b0000, "after_rst");

    // rst and start in the same cycle: rst wins
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 16'h0101;
    b_in  = 16'h0202;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {31'b0, busy}, 32'd0);
    step();
    chk("rst_start_busy2", {31'b0, busy}, 32'd0);
    chk("rst_start_sum",   {16'b0, sum},  32'd0);

    // Randomised operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef BK_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if (rs) full = {1'b0, ra} - {1'b0, rb} + 17'h10000;
      else    full = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, rs, full[W-1:0], full[W], ref_cin(ra, rb, rs), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) step();
    end

    // NIBBLES=1: a single RUN cycle, done two cycles after start
    a_in_1  = 4'hF;
    b_in_1  = 4'h1;
    start_1 = 1'b1;
    step();
    start_1 = 1'b0;
    chk("n1_run_busy",  {31'b0, busy_1},    32'd1);
    chk("n1_run_done",  {31'b0, done_1},    32'd0);
    chk("n1_run_add_a", {28'b0, add_a_1},   32'hF);
    chk("n1_run_cin",   {31'b0, add_cin_1}, 32'd0);
    step();
    chk("n1_done", {31'b0, done_1}, 32'd1);
    step();
    chk("n1_done_off",  {31'b0, done_1},      32'd0);
    chk("n1_busy_off",  {31'b0, busy_1},      32'd0);
    chk("n1_sum",       {28'b0, sum_1},       32'h0);
    chk("n1_carry_out", {31'b0, carry_out_1}, 32'd1);
    a_in_1  = 4'h7;
    b_in_1  = 4'h8;
    start_1 = 1'b1;
    step();
    start_1 = 1'b0;
    step();
    chk("n1b_done", {31'b0, done_1}, 32'd1);
    step();
    chk("n1b_sum",       {28'b0, sum_1},       32'hF);
    chk("n1b_carry_out", {31'b0, carry_out_1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
